// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default, 8E1 (even parity) when RX_PARITY_EN is defined.
// Samples the synchronized line at bit centres using a 16-bit baud counter.
module uart_rx #(
  parameter int unsigned BAUD_PER = 868
) (
  input  logic       clk_100MHz,
  input  logic       rst_i,
  input  logic       uartrx_ser_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       busy_o
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_PER - 1);
  localparam logic [15:0] HALF_LAST = 16'((BAUD_PER / 2) - 1);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

  state_t      state_reg, state_next;
  logic        sync1_reg, sync2_reg, prev_reg;
  logic [15:0] cnt_reg;
  logic [2:0]  bit_cnt_reg;
  logic [7:0]  shift_reg;

  logic line, fall, half_hit, baud_hit;
  logic cnt_clear, shift_en, bit_clear, load_byte, frame_err_set, par_sample;

  assign line     = sync2_reg;
  assign fall     = prev_reg & ~line;
  assign half_hit = (cnt_reg == HALF_LAST);
  assign baud_hit = (cnt_reg == BAUD_LAST);
  assign busy_o   = (state_reg != IDLE);

  // Synchronizer plus one extra stage for falling-edge detection.
  always_ff @(posedge clk_100MHz or posedge rst_i) begin
    if (rst_i) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
    end else begin
      sync1_reg <= uartrx_ser_i;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  always_ff @(posedge clk_100MHz or posedge rst_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (fall) state_next = START;
      START:     if (half_hit) state_next = line ? IDLE : DATA;
`ifdef RX_PARITY_EN
      DATA:      if (baud_hit && bit_cnt_reg == 3'd7) state_next = PARITY;
      PARITY:    if (baud_hit) state_next = STOP;
`else
      DATA:      if (baud_hit && bit_cnt_reg == 3'd7) state_next = STOP;
`endif
      STOP:      if (baud_hit) state_next = line ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (line) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_clear     = 1'b0;
    shift_en      = 1'b0;
    bit_clear     = 1'b0;
    load_byte     = 1'b0;
    frame_err_set = 1'b0;
    par_sample    = 1'b0;
    case (state_reg)
      IDLE:      cnt_clear = 1'b1;
      START: begin
        cnt_clear = half_hit;
        bit_clear = 1'b1;
      end
      DATA: begin
        cnt_clear = baud_hit;
        shift_en  = baud_hit;
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        cnt_clear  = baud_hit;
        par_sample = baud_hit;
      end
`endif
      STOP: begin
        cnt_clear     = baud_hit;
        load_byte     = baud_hit & line;
        frame_err_set = baud_hit & ~line;
      end
      WAIT_IDLE: cnt_clear = 1'b1;
      default:   cnt_clear = 1'b1;
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg     <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
    end else begin
      cnt_reg <= cnt_clear ? 16'd0 : cnt_reg + 16'd1;
      if (bit_clear)     bit_cnt_reg <= '0;
      else if (shift_en) bit_cnt_reg <= bit_cnt_reg + 3'd1;
      if (shift_en) shift_reg <= {line, shift_reg[7:1]};
    end
  end

  always_ff @(posedge clk_100MHz or posedge rst_i) begin
    if (rst_i) begin
      rx_data_o   <= 8'h00;
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      rx_valid_o  <= load_byte;
      frame_err_o <= frame_err_set;
      if (load_byte) rx_data_o <= shift_reg;
    end
  end

`ifdef RX_PARITY_EN
  logic par_bad_reg;

  // Mismatch is held until the stop bit decides whether the byte is delivered.
  always_ff @(posedge clk_100MHz or posedge rst_i) begin
    if (rst_i) begin
      par_bad_reg  <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      if (par_sample) par_bad_reg <= (line != ^shift_reg);
      parity_err_o <= load_byte & par_bad_reg;
    end
  end
`else
  assign parity_err_o = 1'b0;
  logic unused_par;
  assign unused_par = par_sample;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 10 clocks per bit: table of frames plus
// hand-written glitch, framing-error, back-to-back and mid-frame reset sequences.
module tb_uart_rx;
  localparam int BAUD = 10;
`ifdef RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ser = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, busy;

  uart_rx #(.BAUD_PER(BAUD)) dut (
    .clk_100MHz   (clk),
    .rst_i        (rst),
    .uartrx_ser_i (ser),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .frame_err_o  (frame_err),
    .parity_err_o (parity_err),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  logic [7:0] data_log [64];

  always @(negedge clk) begin
    if (rx_valid) begin
      data_log[valid_cnt % 64] = rx_data;
      valid_cnt++;
    end
    if (frame_err)  ferr_cnt++;
    if (parity_err) perr_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    ser = 1'b0;
    wait_cycles(BAUD);
    for (int i = 0; i < 8; i++) begin
      ser = d[i];
      wait_cycles(BAUD);
    end
    if (PAR_EN) begin
      ser = p;
      wait_cycles(BAUD);
    end
    ser = stop;
    wait_cycles(BAUD);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par_bit;
    int         exp_perr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int vb, fb, pb;
    logic [7:0] exp_last;

    vecs.push_back('{8'hA5, 1'b0, 0});
    vecs.push_back('{8'h00, 1'b0, 0});
    vecs.push_back('{8'h96, 1'b0, 0});
    if (PAR_EN) begin
      vecs.push_back('{8'h07, 1'b0, 1});
      vecs.push_back('{8'h07, 1'b1, 0});
    end
    vecs.push_back('{8'hFF, 1'b0, 0});

    // Reset state
    wait_cycles(3);
    @(negedge clk);
    check("reset rx_data", {24'd0, rx_data}, 32'h00);
    check("reset rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset frame_err", {31'd0, frame_err}, 32'd0);
    check("reset parity_err", {31'd0, parity_err}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_cycles(5);

    // Table-driven frames
    exp_last = 8'h00;
    foreach (vecs[k]) begin
      vb = valid_cnt; fb = ferr_cnt; pb = perr_cnt;
      send_frame(vecs[k].data, vecs[k].par_bit, 1'b1);
      ser = 1'b1;
      wait_cycles(3 * BAUD);
      $display("frame %0d: sent %02h, got %02h, valids %0d, parity_err %0d",
               k, vecs[k].data, rx_data, valid_cnt - vb, perr_cnt - pb);
      check("table valid count", 32'(valid_cnt - vb), 32'd1);
      check("table rx_data", {24'd0, rx_data}, {24'd0, vecs[k].data});
      check("table frame_err count", 32'(ferr_cnt - fb), 32'd0);
      check("table parity_err count", 32'(perr_cnt - pb), 32'(vecs[k].exp_perr));
      check("table busy idle", {31'd0, busy}, 32'd0);
      exp_last = vecs[k].data;
    end

    // Short low glitch is rejected
    vb = valid_cnt; fb = ferr_cnt;
    ser = 1'b0;
    wait_cycles(3);
    ser = 1'b1;
    @(negedge clk);
    check("glitch busy in start", {31'd0, busy}, 32'd1);
    wait_cycles(6);
    $display("glitch: busy %0b, valids %0d, frame_errs %0d", busy, valid_cnt - vb, ferr_cnt - fb);
    check("glitch back to idle", {31'd0, busy}, 32'd0);
    check("glitch no valid", 32'(valid_cnt - vb), 32'd0);
    check("glitch no frame_err", 32'(ferr_cnt - fb), 32'd0);

    // Stop bit low followed by a break: one frame error, data held
    vb = valid_cnt; fb = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_cycles(30);
    $display("frame error: frame_errs %0d, valids %0d, rx_data %02h, busy %0b",
             ferr_cnt - fb, valid_cnt - vb, rx_data, busy);
    check("break frame_err count", 32'(ferr_cnt - fb), 32'd1);
    check("break no valid", 32'(valid_cnt - vb), 32'd0);
    check("break rx_data held", {24'd0, rx_data}, {24'd0, exp_last});
    check("break busy high", {31'd0, busy}, 32'd1);
    ser = 1'b1;
    wait_cycles(5);
    check("break busy released", {31'd0, busy}, 32'd0);
    check("break single frame_err", 32'(ferr_cnt - fb), 32'd1);
    wait_cycles(2 * BAUD);

    // Back-to-back frames with no idle gap
    vb = valid_cnt;
    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    ser = 1'b1;
    wait_cycles(3 * BAUD);
    $display("back-to-back: valids %0d, first %02h, second %02h",
             valid_cnt - vb, data_log[vb % 64], data_log[(vb + 1) % 64]);
    check("b2b valid count", 32'(valid_cnt - vb), 32'd2);
    check("b2b first byte", {24'd0, data_log[vb % 64]}, 32'h55);
    check("b2b second byte", {24'd0, data_log[(vb + 1) % 64]}, 32'hFF);

    // Reset during data bit 4 of 0x0F, then a clean 0x81
    ser = 1'b0;
    wait_cycles(BAUD);
    for (int i = 0; i < 4; i++) begin
      ser = 1'b1;
      wait_cycles(BAUD);
    end
    ser = 1'b0;
    wait_cycles(5);
    rst = 1'b1;
    @(negedge clk);
    $display("mid-frame reset: rx_data %02h, valid %0b, frame_err %0b, busy %0b",
             rx_data, rx_valid, frame_err, busy);
    check("midreset rx_data", {24'd0, rx_data}, 32'h00);
    check("midreset rx_valid", {31'd0, rx_valid}, 32'd0);
    check("midreset frame_err", {31'd0, frame_err}, 32'd0);
    check("midreset parity_err", {31'd0, parity_err}, 32'd0);
    check("midreset busy", {31'd0, busy}, 32'd0);
    ser = 1'b1;
    wait_cycles(4);
    rst = 1'b0;
    wait_cycles(2 * BAUD);
    vb = valid_cnt; fb = ferr_cnt;
    send_frame(8'h81, 1'b0, 1'b1);
    ser = 1'b1;
    wait_cycles(3 * BAUD);
    $display("after reset: valids %0d, rx_data %02h", valid_cnt - vb, rx_data);
    check("postreset valid count", 32'(valid_cnt - vb), 32'd1);
    check("postreset rx_data", {24'd0, rx_data}, 32'h81);
    check("postreset no frame_err", 32'(ferr_cnt - fb), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD_PER, default 868: clock cycles per bit (100 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port clk_100MHz  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port uartrx_ser_i  input  1  asynchronous serial line, idle high, 8N1 format (8E1 under RX_PARITY_EN).
REQ-005 SHALL have port rx_data_o  output  8  last correctly framed byte; held until the next byte is accepted.
REQ-006 SHALL have port rx_valid_o  output  1  one-cycle pulse when rx_data_o updates.
REQ-007 SHALL have port frame_err_o  output  1  one-cycle pulse when a stop bit samples low.
REQ-008 SHALL have port parity_err_o  output  1  one-cycle pulse on parity mismatch; constant 0 without RX_PARITY_EN.
REQ-009 SHALL have port busy_o  output  1  high in every state except IDLE.

Function
REQ-010 SHALL synchronize uartrx_ser_i through a 2-flop synchronizer reset to 1; all decoding uses the synchronized signal.
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY (only with RX_PARITY_EN), STOP, WAIT_IDLE.
REQ-012 IDLE: a synchronized 1->0 transition SHALL enter START and clear the baud counter.
REQ-013 START: after floor(BAUD_PER/2) cycles SHALL sample the line; 0 -> DATA with counter cleared; 1 -> IDLE (glitch rejection, no output pulse).
REQ-014 DATA: SHALL sample every BAUD_PER cycles at bit centre, shifting LSB first; after bit 7 SHALL enter PARITY or STOP.
REQ-015 PARITY: SHALL sample one bit BAUD_PER cycles later and compare it against even parity of the 8 data bits.
REQ-016 STOP: SHALL sample BAUD_PER cycles later; on 1, SHALL load rx_data_o and pulse rx_valid_o in the next cycle, then enter IDLE.
REQ-017 STOP sampling 0: SHALL pulse frame_err_o, SHALL NOT pulse rx_valid_o, SHALL leave rx_data_o unchanged, and SHALL enter WAIT_IDLE.
REQ-018 WAIT_IDLE: SHALL return to IDLE only after the synchronized line reads 1, so a break condition produces exactly one frame_err_o.
REQ-019 parity_err_o SHALL pulse in the same cycle as rx_valid_o, and the byte SHALL still be delivered.
REQ-020 The baud counter SHALL be 16 bits wide, counting 0..BAUD_PER-1 and wrapping to 0 on each sample.
REQ-021 A falling edge arriving in the same cycle that STOP completes SHALL be detected, allowing back-to-back frames with no idle gap.
REQ-022 Latency from the line edge of the stop-bit centre to rx_valid_o SHALL be 2 cycles (synchronizer) + 1 cycle (register).

Reset
REQ-023 On rst_i high, SHALL enter IDLE asynchronously, set rx_data_o=8'h00, rx_valid_o=0, frame_err_o=0, parity_err_o=0, busy_o=0, clear the counter and shift register, and set the synchronizer flops to 1.
REQ-024 Reset asserted mid-frame SHALL discard the partial byte; after release, the next falling edge SHALL start a new frame.

Configuration
REQ-025 Macro RX_PARITY_EN defined: SHALL compile in the PARITY state (8E1 frame, 11 bits) and the parity_err_o logic.
REQ-026 Macro RX_PARITY_EN undefined: SHALL omit the PARITY state (8N1 frame, 10 bits) and tie parity_err_o to 0.

Verification (BAUD_PER=10)
REQ-027 Drive 8N1 byte 8'hA5 at 10 cycles/bit -> exactly one rx_valid_o pulse, rx_data_o=8'hA5, busy_o low afterwards.
REQ-028 Drive a 3-cycle low glitch on an idle line -> no rx_valid_o, no frame_err_o; FSM back in IDLE by cycle 8.
REQ-029 Drive byte 8'h3C with stop bit 0, holding the line low for 30 more cycles -> one frame_err_o pulse, rx_data_o unchanged, busy_o high until the line goes high.
REQ-030 Drive bytes 8'h55 and 8'hFF back to back with no idle gap -> two rx_valid_o pulses carrying 8'h55 then 8'hFF.
REQ-031 Assert rst_i during data bit 4 of 8'h0F, then release and send 8'h81 -> only 8'h81 is reported; all outputs are 0 while in reset.
REQ-032 With RX_PARITY_EN defined, send 8'h07 with parity bit 0 -> rx_valid_o pulses with rx_data_o=8'h07 and parity_err_o=1; with parity bit 1 -> parity_err_o=0.
